alu_requester: RTL and testbench

//  Initiator side of the ALU operand/result interface (A, B, op -> R). Accepts one command over a

---
 rtl/alu_requester_if.sv | 30 +++
 rtl/alu_requester.sv | 102 ++++++++++
 tb/tb_alu_requester.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_requester_if.sv
// Handshake and ALU operand/result bundle between the requester and its environment.
// The master side is the requester; the slave side is the command source, ALU and response sink.
interface alu_requester_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic [WIDTH-1:0] R;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [WIDTH-1:0] resp_exp;
  logic             resp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, R, resp_ready,
    output cmd_ready, A, B, op, resp_valid, resp_data, resp_exp, resp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, R, resp_ready,
    input  cmd_ready, A, B, op, resp_valid, resp_data, resp_exp, resp_err
  );
endinterface

// File: rtl/alu_requester.sv
// ALU initiator: accepts one command, drives the ALU, samples R after LATENCY stages,
// compares it against an internal reference and reports pass/fail with saturating tallies.
module alu_requester #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_requester_if.master  bus,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int LW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic          mismatch;

  function automatic logic [WIDTH-1:0] model(input logic [2:0] f,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (f)
      3'd0:    y = a + b;
      3'd1:    y = ~a;
      3'd2:    y = a - b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = a & b;
      3'd6:    y = {a[WIDTH-2:0], 1'b0};
      default: y = {1'b0, a[WIDTH-1:1]};
    endcase
    return y;
  endfunction

  assign mismatch = (bus.R != bus.resp_exp);

  // lat_cnt counts the ALU stages still in flight; R is sampled on the edge after it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.A           <= '0;
      bus.B           <= '0;
      bus.op          <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_exp    <= '0;
      bus.resp_err    <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.A         <= bus.cmd_a;
            bus.B         <= bus.cmd_b;
            bus.op        <= bus.cmd_op;
            bus.resp_exp  <= model(bus.cmd_op, bus.cmd_a, bus.cmd_b);
            lat_cnt       <= LW'(LATENCY);
            bus.cmd_ready <= 1'b0;
            state         <= DRIVE;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        DRIVE: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            bus.resp_data  <= bus.R;
            bus.resp_err   <= mismatch;
            bus.resp_valid <= 1'b1;
            if (mismatch) begin
              if (!(&fail_cnt)) fail_cnt <= fail_cnt + 1'b1;
            end else begin
              if (!(&pass_cnt)) pass_cnt <= pass_cnt + 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.cmd_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester: a one-stage ALU model feeds R, and responses are compared with a
// reference computed from plain integer arithmetic plus fixed vectors for the named cases.
module tb_alu_requester;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 1;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             faultOp1;

  int checksDone;
  int checksPassed;
  int expPass;
  int expFail;

  alu_requester_if #(.WIDTH(WIDTH)) bus ();

  alu_requester #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from integer arithmetic modulo 256.
  function automatic logic [7:0] refModel(input int f, input int a, input int b);
    int r;
    case (f)
      0:       r = (a + b) % 256;
      1:       r = 255 - a;
      2:       r = (a - b + 256) % 256;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = a & b;
      6:       r = (a * 2) % 256;
      default: r = a / 2;
    endcase
    return 8'(r);
  endfunction

  // Single-register ALU, with an optional stuck-at-zero fault on NOT.
  always @(posedge clk) begin
    if (faultOp1 && bus.op == 3'd1) bus.R <= 8'h00;
    else bus.R <= refModel(int'(bus.op), int'(bus.A), int'(bus.B));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksDone++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else checksPassed++;
  endtask

  // Called at a negedge; leaves the bench at the negedge after the response is consumed
  // (or at the negedge where it first appears when resp_ready is low).
  task automatic applyStimulus(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] expData, input logic [7:0] expExp,
                               input logic expErr, input string name);
    int waitCnt;
    int lat;
    bus.cmd_op    = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    waitCnt = 0;
    while (!bus.cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({name, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = ~a;
    bus.cmd_b     = ~b;
    bus.cmd_op    = ~f;
    checkOutput({name, " op"}, 32'(bus.op), 32'(f));
    checkOutput({name, " A"}, 32'(bus.A), 32'(a));
    checkOutput({name, " B"}, 32'(bus.B), 32'(b));
    checkOutput({name, " busy"}, 32'(bus.cmd_ready), 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(LATENCY + 2));
    if (expErr) expFail++;
    else expPass++;
    checkOutput({name, " resp_data"}, 32'(bus.resp_data), 32'(expData));
    checkOutput({name, " resp_exp"}, 32'(bus.resp_exp), 32'(expExp));
    checkOutput({name, " resp_err"}, 32'(bus.resp_err), 32'(expErr));
    checkOutput({name, " pass_cnt"}, 32'(pass_cnt), 32'(expPass));
    checkOutput({name, " fail_cnt"}, 32'(fail_cnt), 32'(expFail));
    if (bus.resp_ready) begin
      @(negedge clk);
      checkOutput({name, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [2:0] rop;
    logic [7:0] ra, rb, rexp;
    logic [7:0] heldData;

    vecs[0] = '{3'd0, 8'hAA, 8'h55, 8'hFF, "add aa55"};
    vecs[1] = '{3'd1, 8'hAA, 8'h55, 8'h55, "not aa"};
    vecs[2] = '{3'd5, 8'hAA, 8'h55, 8'h00, "and aa55"};
    vecs[3] = '{3'd0, 8'hFF, 8'h01, 8'h00, "add wrap"};
    vecs[4] = '{3'd2, 8'h00, 8'h01, 8'hFF, "sub wrap"};
    vecs[5] = '{3'd6, 8'h81, 8'h00, 8'h02, "shl wrap"};

    checksDone     = 0;
    checksPassed   = 0;
    expPass        = 0;
    expFail        = 0;
    faultOp1       = 1'b0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_a      = 8'h00;
    bus.cmd_b      = 8'h00;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst A", 32'(bus.A), 32'd0);
    checkOutput("rst op", 32'(bus.op), 32'd0);
    checkOutput("rst resp_data", 32'(bus.resp_data), 32'd0);
    checkOutput("rst resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("rst fail_cnt", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-rst cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Fixed vectors, including wraparound cases
    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp, 1'b0, vecs[i].name);

    // Randomized commands against the reference model
    for (int i = 0; i < 24; i++) begin
      r    = int'($urandom_range(0, 7));
      rop  = 3'(r);
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rexp = refModel(r, int'(ra), int'(rb));
      applyStimulus(rop, ra, rb, rexp, rexp, 1'b0, "random");
    end

    // Faulty ALU on NOT
    faultOp1 = 1'b1;
    applyStimulus(3'd1, 8'hAA, 8'h00, 8'h00, 8'h55, 1'b1, "fault not");
    faultOp1 = 1'b0;

    // Backpressure: response held while resp_ready is low
    bus.resp_ready = 1'b0;
    applyStimulus(3'd4, 8'h3C, 8'h0F, 8'h33, 8'h33, 1'b0, "backpressure");
    heldData = bus.resp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold resp_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("hold cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("hold resp_data", 32'(bus.resp_data), 32'(heldData));
      checkOutput("hold op", 32'(bus.op), 32'd4);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("release cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Reset while in DRIVE abandons the transaction
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h12;
    bus.cmd_b     = 8'h34;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expPass = 0;
    expFail = 0;
    checkOutput("drive-rst pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("drive-rst fail_cnt", 32'(fail_cnt), 32'd0);
    checkOutput("drive-rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("drive-rst A", 32'(bus.A), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("drive-rst no resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    checkOutput("drive-rst idle ready", 32'(bus.cmd_ready), 32'd1);

    applyStimulus(3'd7, 8'h81, 8'h00, 8'h40, 8'h40, 1'b0, "shr after rst");

    $display("[TB] %0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
